// File: rtl/bram_porta_arb.sv
// bram_porta_arb: round-robin arbiter sharing BRAM port A among NUM_REQ requesters
//
// Ports:
//   clockIn        single clock, also the BRAM port-A clock
//   resetNIn       asynchronous active-low reset
//   reqValidIn     per-requester beat valid
//   reqReadyOut    per-requester beat accepted this cycle (one-hot or zero)
//   reqWrEnIn      per-requester 1 = write beat, 0 = read beat
//   reqLastIn      per-requester final beat of a burst
//   reqAddrIn      packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   reqDataIn      packed write data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rspValidOut    read response valid, two cycles after the read beat
//   rspIdOut       requester index of the response
//   rspDataOut     read data straight from the BRAM output register
//   bramEnOut_a    BRAM enIn_a
//   bramWrEnOut_a  BRAM wrEnIn_a
//   bramAddrOut_a  BRAM addrIn_a
//   bramDataOut_a  BRAM dataIn_a
//   bramDataIn_a   BRAM dataOut_a
module bram_porta_arb #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_BURST  = 4,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                             clockIn,
    input  logic                             resetNIn,
    input  logic [NUM_REQ-1:0]               reqValidIn,
    output logic [NUM_REQ-1:0]               reqReadyOut,
    input  logic [NUM_REQ-1:0]               reqWrEnIn,
    input  logic [NUM_REQ-1:0]               reqLastIn,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    reqAddrIn,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    reqDataIn,
    output logic                             rspValidOut,
    output logic [ID_W-1:0]                  rspIdOut,
    output logic [DATA_WIDTH-1:0]            rspDataOut,
    output logic                             bramEnOut_a,
    output logic                             bramWrEnOut_a,
    output logic [ADDR_WIDTH-1:0]            bramAddrOut_a,
    output logic [DATA_WIDTH-1:0]            bramDataOut_a,
    input  logic [DATA_WIDTH-1:0]            bramDataIn_a
);
    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    typedef enum logic {ARB, BURST} state_t;

    state_t                state, stateNext;
    logic [ID_W-1:0]       ptr, ptrNext, owner, ownerNext, winner, idx;
    logic [CNT_W-1:0]      beatCnt, beatCntNext, cntInc;
    logic                  grant, winWrEn, winLast;
    logic [ADDR_WIDTH-1:0] winAddr;
    logic [DATA_WIDTH-1:0] winData;
    logic                  rspValid1, rspValid2;
    logic [ID_W-1:0]       rspId1, rspId2;

    // Increment modulo NUM_REQ, which need not be a power of two.
    function automatic logic [ID_W-1:0] incMod(input logic [ID_W-1:0] x);
        return (int'(x) == NUM_REQ - 1) ? '0 : x + 1'b1;
    endfunction

    // Winner selection. Scanning offsets from highest to lowest lets the
    // nearest valid requester after ptr overwrite any farther one.
    always_comb begin
        grant  = 1'b0;
        winner = '0;
        idx    = '0;
        if (resetNIn) begin
            if (state == ARB) begin
                for (int k = NUM_REQ - 1; k >= 0; k--) begin
                    idx = (int'(ptr) + k >= NUM_REQ) ? ID_W'(int'(ptr) + k - NUM_REQ) : ID_W'(int'(ptr) + k);
                    if (reqValidIn[idx]) begin
                        grant  = 1'b1;
                        winner = idx;
                    end
                end
            end else begin
                grant  = reqValidIn[owner];
                winner = owner;
            end
        end
    end

    always_comb begin
        winWrEn = 1'b0;
        winLast = 1'b0;
        winAddr = '0;
        winData = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (winner == ID_W'(k)) begin
                winWrEn = reqWrEnIn[k];
                winLast = reqLastIn[k];
                winAddr = reqAddrIn[k*ADDR_WIDTH +: ADDR_WIDTH];
                winData = reqDataIn[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign reqReadyOut = grant ? (NUM_REQ'(1) << winner) : '0;

    // A burst ends on last, on reaching MAX_BURST, or when the owner drops
    // valid; in every case the owner moves to the back of the rotation.
    always_comb begin
        stateNext   = state;
        ptrNext     = ptr;
        ownerNext   = owner;
        beatCntNext = beatCnt;
        cntInc      = beatCnt + 1'b1;
        if (state == ARB) begin
            if (grant) begin
                if (winLast || MAX_BURST == 1) begin
                    ptrNext = incMod(winner);
                end else begin
                    stateNext   = BURST;
                    ownerNext   = winner;
                    beatCntNext = CNT_W'(1);
                end
            end
        end else if (grant) begin
            beatCntNext = cntInc;
            if (winLast || cntInc == CNT_W'(MAX_BURST)) begin
                stateNext = ARB;
                ptrNext   = incMod(owner);
            end
        end else begin
            stateNext = ARB;
            ptrNext   = incMod(owner);
        end
    end

    always_ff @(posedge clockIn or negedge resetNIn) begin
        if (!resetNIn) begin
            state         <= ARB;
            ptr           <= '0;
            owner         <= '0;
            beatCnt       <= '0;
            bramEnOut_a   <= 1'b0;
            bramWrEnOut_a <= 1'b0;
            bramAddrOut_a <= '0;
            bramDataOut_a <= '0;
            rspValid1     <= 1'b0;
            rspValid2     <= 1'b0;
            rspId1        <= '0;
            rspId2        <= '0;
        end else begin
            state         <= stateNext;
            ptr           <= ptrNext;
            owner         <= ownerNext;
            beatCnt       <= beatCntNext;
            bramEnOut_a   <= grant;
            bramWrEnOut_a <= grant && winWrEn;
            if (grant) begin
                bramAddrOut_a <= winAddr;
                bramDataOut_a <= winData;
            end
            // Writes get no response even though the BRAM echoes write data.
            rspValid1     <= grant && !winWrEn;
            rspId1        <= winner;
            rspValid2     <= rspValid1;
            rspId2        <= rspId1;
        end
    end

    assign rspValidOut = rspValid2;
    assign rspIdOut    = rspId2;
    assign rspDataOut  = bramDataIn_a;
endmodule

// File: tb/tb_bram_porta_arb.sv
// tb_bram_porta_arb: scoreboard bench for bram_porta_arb with a write-first BRAM port-A model
module tb_bram_porta_arb;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            resetNIn;
    logic [N-1:0]    reqValid = '0, reqReady, reqWrEn = '0, reqLast = '0;
    logic [N*AW-1:0] reqAddr = '0;
    logic [N*DW-1:0] reqData = '0;
    logic            rspValid;
    logic [1:0]      rspId;
    logic [DW-1:0]   rspData;
    logic            bramEn, bramWrEn;
    logic [AW-1:0]   bramAddr;
    logic [DW-1:0]   bramDout, bramDin;

    bram_porta_arb #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(4)) dut (
        .clockIn(clk), .resetNIn(resetNIn),
        .reqValidIn(reqValid), .reqReadyOut(reqReady), .reqWrEnIn(reqWrEn), .reqLastIn(reqLast),
        .reqAddrIn(reqAddr), .reqDataIn(reqData),
        .rspValidOut(rspValid), .rspIdOut(rspId), .rspDataOut(rspData),
        .bramEnOut_a(bramEn), .bramWrEnOut_a(bramWrEn), .bramAddrOut_a(bramAddr),
        .bramDataOut_a(bramDout), .bramDataIn_a(bramDin)
    );

    logic [DW-1:0] mem [1<<AW];
    always @(posedge clk) begin
        if (bramEn) begin
            if (bramWrEn) mem[bramAddr] <= bramDout;
            bramDin <= bramWrEn ? bramDout : mem[bramAddr];
        end
    end

    int checks = 0, errors = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {bit idle; bit wr; bit last; logic [AW-1:0] addr; logic [DW-1:0] data;} beat_t;
    typedef struct {int id; logic [DW-1:0] data; int due;} rsp_t;
    beat_t bq[N][$];
    rsp_t  sb[$];
    int    grantLog[$];
    logic [N-1:0] acc;

    task automatic push(int i, bit idle, bit wr, int a, int d, bit l);
        beat_t b;
        b.idle = idle; b.wr = wr; b.last = l; b.addr = AW'(a); b.data = DW'(d);
        bq[i].push_back(b);
    endtask
    task automatic wrB(int i, int a, int d, bit l); push(i, 0, 1, a, d, l); endtask
    task automatic rdB(int i, int a, int e, bit l); push(i, 0, 0, a, e, l); endtask
    task automatic idleB(int i); push(i, 1, 0, 0, 0, 0); endtask

    // Driver: sample acceptance mid-cycle, retire beats after the edge, present next heads.
    always begin
        @(negedge clk);
        acc = reqReady & reqValid;
        if (resetNIn && reqValid != 0) begin
            int g;
            g = 15;
            for (int i = 0; i < N; i++) if (reqReady[i]) g = i;
            grantLog.push_back(g);
            checks++;
            if ((reqReady & ~reqValid) != 0 || $countones(reqReady) > 1) begin
                errors++;
                $display("FAIL ready_onehot: ready=%b valid=%b", reqReady, reqValid);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (acc[i] && bq[i].size() > 0 && !bq[i][0].wr) begin
                rsp_t r;
                r.id = i; r.data = bq[i][0].data; r.due = cyc + 2;
                sb.push_back(r);
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (bq[i].size() > 0 && (acc[i] || bq[i][0].idle)) bq[i].delete(0);
        for (int i = 0; i < N; i++) begin
            if (bq[i].size() > 0 && !bq[i][0].idle) begin
                reqValid[i] = 1'b1;
                reqWrEn[i]  = bq[i][0].wr;
                reqLast[i]  = bq[i][0].last;
                reqAddr[i*AW +: AW] = bq[i][0].addr;
                reqData[i*DW +: DW] = bq[i][0].data;
            end else begin
                reqValid[i] = 1'b0;
                reqWrEn[i]  = 1'b0;
                reqLast[i]  = 1'b0;
                reqAddr[i*AW +: AW] = '0;
                reqData[i*DW +: DW] = '0;
            end
        end
    end

    // Monitor: every response must match the oldest expectation, on its due cycle.
    always @(negedge clk) begin
        rsp_t r;
        if (rspValid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got id=%0d data=%h at cycle %0d, expected none", rspId, rspData, cyc);
            end else begin
                r = sb.pop_front();
                if (int'(rspId) != r.id || rspData !== r.data || cyc != r.due) begin
                    errors++;
                    $display("FAIL rsp: got id=%0d data=%h cycle=%0d, expected id=%0d data=%h cycle=%0d",
                             rspId, rspData, cyc, r.id, r.data, r.due);
                end
            end
        end
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit busy();
        for (int i = 0; i < N; i++) if (bq[i].size() > 0) return 1'b1;
        return sb.size() != 0 || reqValid != 0;
    endfunction

    task automatic drain(string name);
        int n;
        n = 0;
        while (busy() && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drain"}, 64'(busy()), 64'd0);
    endtask

    task automatic expectGrants(string name, int n, logic [63:0] seq);
        logic [63:0] act;
        act = '0;
        foreach (grantLog[k]) act = (act << 4) | 64'(grantLog[k]);
        checks++;
        if (grantLog.size() != n || act !== seq) begin
            errors++;
            $display("FAIL grants_%s: got %0d grants %h, expected %0d grants %h", name, grantLog.size(), act, n, seq);
        end
        grantLog.delete();
    endtask

    task automatic checkIdle(string name);
        chk({name, "_ready"}, 64'(reqReady), 64'd0);
        chk({name, "_rspValid"}, 64'(rspValid), 64'd0);
        chk({name, "_rspId"}, 64'(rspId), 64'd0);
        chk({name, "_en"}, 64'(bramEn), 64'd0);
        chk({name, "_we"}, 64'(bramWrEn), 64'd0);
        chk({name, "_addr"}, 64'(bramAddr), 64'd0);
        chk({name, "_data"}, 64'(bramDout), 64'd0);
    endtask

    initial begin
        resetNIn = 1'b0;
        repeat (3) @(negedge clk);
        checkIdle("reset");
        @(posedge clk); #3 resetNIn = 1'b1;

        wrB(0, 5, 'hA5, 1); wrB(0, 6, 'h11, 1); wrB(0, 7, 'h22, 1); wrB(0, 8, 'h33, 1); wrB(0, 9, 'h44, 1);
        drain("prewrite");
        expectGrants("prewrite", 5, 'h00000);

        rdB(2, 5, 'hA5, 1);
        for (int n = 0; n < 20 && reqReady == 0; n++) @(negedge clk);
        chk("single_ready", 64'(reqReady), 64'b0100);
        chk("single_rsp_T", 64'(rspValid), 64'd0);
        @(negedge clk);
        chk("single_en", 64'(bramEn), 64'd1);
        chk("single_we", 64'(bramWrEn), 64'd0);
        chk("single_addr", 64'(bramAddr), 64'd5);
        chk("single_rsp_T1", 64'(rspValid), 64'd0);
        drain("single");
        expectGrants("single", 1, 'h2);

        for (int r = 0; r < 2; r++) begin
            rdB(0, 5, 'hA5, 1); rdB(1, 6, 'h11, 1); rdB(2, 7, 'h22, 1); rdB(3, 8, 'h33, 1);
        end
        drain("rr");
        expectGrants("rr", 8, 'h30123012);

        rdB(0, 9, 'h44, 1); rdB(0, 5, 'hA5, 1);
        rdB(1, 6, 'h11, 0); rdB(1, 7, 'h22, 0); rdB(1, 8, 'h33, 1);
        rdB(2, 5, 'hA5, 1);
        drain("burst_lock");
        expectGrants("burst_lock", 6, 'h011120);

        for (int k = 0; k < 5; k++) wrB(3, 20 + k, 'h61 + k, 0);
        rdB(3, 24, 'h65, 1);
        drain("cut");
        expectGrants("cut", 6, 'h333333);

        rdB(1, 5, 'hA5, 1); rdB(1, 6, 'h11, 1);
        for (int k = 0; k < 5; k++) rdB(3, 20 + k, 'h61 + k, 0);
        rdB(3, 24, 'h65, 1);
        drain("cut_contend");
        expectGrants("cut_contend", 8, 'h13333133);

        rdB(0, 5, 'hA5, 0); idleB(0); rdB(0, 6, 'h11, 1);
        rdB(1, 7, 'h22, 1);
        drain("bubble");
        expectGrants("bubble", 4, 'h0F10);

        rdB(1, 9, 'h44, 1);
        rdB(2, 5, 'hA5, 0); rdB(2, 6, 'h11, 0); rdB(2, 7, 'h22, 0); rdB(2, 8, 'h33, 1);
        for (int n = 0; n < 50 && grantLog.size() < 3; n++) @(negedge clk);
        chk("mid_grants", 64'(grantLog.size()), 64'd3);
        @(posedge clk); #3 resetNIn = 1'b0;
        #1 checkIdle("mid_reset");
        sb.delete();
        grantLog.delete();
        for (int i = 0; i < N; i++) bq[i].delete();
        rdB(3, 8, 'h33, 1); rdB(1, 6, 'h11, 1);
        repeat (2) @(negedge clk);
        chk("reset_ready_masked", 64'(reqReady), 64'd0);
        chk("reset_rsp", 64'(rspValid), 64'd0);
        @(posedge clk); #3 resetNIn = 1'b1;
        drain("post_reset");
        expectGrants("post_reset", 2, 'h13);

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
